// File: rtl/add_issue_ctrl.sv
// ---------------------------------------------------------------------------
// add_issue_ctrl
//
// Operand issuer and result collector for a registered two-stage adder.
// Operand pairs arrive on a valid/ready input and are buffered in a small
// FIFO. One operation at a time is issued to the adder (start/a/b). The
// adder result y is captured a fixed LAT cycles after the start pulse and
// is returned on a valid/ready output. Every captured result is compared
// against a locally computed sum, and the adder's sticky valid flag is
// checked at each capture. Both error flags are sticky until rst.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   in_valid/in_ready     operand handshake, pair = {in_a, in_b}
//   start, a, b           registered issue pulse and operands to the adder
//   y, valid              adder result and adder sticky valid
//   out_valid/out_ready   result handshake, result = out_sum
//   busy                  FSM not idle or FIFO not empty
//   err_mismatch          sticky: captured y differed from expected sum
//   err_nvalid            sticky: adder valid was low at a capture
// ---------------------------------------------------------------------------
module add_issue_ctrl #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    parameter int LAT   = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         start,
    output logic [W-1:0] a,
    output logic [W-1:0] b,
    input  logic [W-1:0] y,
    input  logic         valid,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_sum,
    output logic         busy,
    output logic         err_mismatch,
    output logic         err_nvalid
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(LAT + 1);

    localparam logic [AW:0]   PTR_ONE = 1;
    localparam logic [CW-1:0] CNT_ONE = 1;
    localparam logic [CW-1:0] CNT_LAT = CW'(LAT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_HOLD
    } state_e;

    // ------------------------------------------------------------------
    // Operand FIFO
    // ------------------------------------------------------------------
    logic [2*W-1:0] mem_q [DEPTH];
    logic [AW:0]    wr_ptr_q;
    logic [AW:0]    rd_ptr_q;
    logic           full;
    logic           empty;
    logic           push;
    logic           pop;
    logic [W-1:0]   head_a;
    logic [W-1:0]   head_b;

    // Pointers carry one extra wrap bit: equal addresses with differing
    // wrap bits means full, identical pointers means empty.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // in_ready is held low while reset is asserted.
    assign in_ready = !full && !rst;
    assign push     = in_valid && in_ready;

    assign {head_a, head_b} = mem_q[rd_ptr_q[AW-1:0]];

    // NOTE: the storage array has no reset; the pointers alone define which
    // entries are meaningful, so clearing the data would only cost logic.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {in_a, in_b};
        end
    end

    // NOTE: sequential state is updated only with non-blocking assignments
    // so every register samples values from before the clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    // ------------------------------------------------------------------
    // Issue / capture FSM
    // ------------------------------------------------------------------
    state_e        state_q,        state_d;
    logic          start_q,        start_d;
    logic [W-1:0]  a_q,            a_d;
    logic [W-1:0]  b_q,            b_d;
    logic [W-1:0]  exp_q,          exp_d;
    logic [W-1:0]  out_sum_q,      out_sum_d;
    logic [CW-1:0] cnt_q,          cnt_d;
    logic          err_mismatch_q, err_mismatch_d;
    logic          err_nvalid_q,   err_nvalid_d;

    // NOTE: every signal written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d        = state_q;
        start_d        = 1'b0;
        a_d            = a_q;
        b_d            = b_q;
        exp_d          = exp_q;
        cnt_d          = cnt_q;
        out_sum_d      = out_sum_q;
        err_mismatch_d = err_mismatch_q;
        err_nvalid_d   = err_nvalid_q;
        pop            = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    a_d     = head_a;
                    b_d     = head_b;
                    start_d = 1'b1;
                    // Carry is dropped, matching the adder's modulo result.
                    exp_d   = head_a + head_b;
                    cnt_d   = CNT_LAT;
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                // WAIT spans the start cycle plus LAT more cycles, so y is
                // sampled at the end of the first cycle it holds the new sum.
                if (cnt_q == '0) begin
                    out_sum_d      = y;
                    err_mismatch_d = err_mismatch_q || (y != exp_q);
                    err_nvalid_d   = err_nvalid_q || !valid;
                    state_d        = S_HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            S_HOLD: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            start_q        <= 1'b0;
            a_q            <= '0;
            b_q            <= '0;
            exp_q          <= '0;
            cnt_q          <= '0;
            out_sum_q      <= '0;
            err_mismatch_q <= 1'b0;
            err_nvalid_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            start_q        <= start_d;
            a_q            <= a_d;
            b_q            <= b_d;
            exp_q          <= exp_d;
            cnt_q          <= cnt_d;
            out_sum_q      <= out_sum_d;
            err_mismatch_q <= err_mismatch_d;
            err_nvalid_q   <= err_nvalid_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign start        = start_q;
    assign a            = a_q;
    assign b            = b_q;
    assign out_valid    = (state_q == S_HOLD);
    assign out_sum      = out_sum_q;
    assign busy         = (state_q != S_IDLE) || !empty;
    assign err_mismatch = err_mismatch_q;
    assign err_nvalid   = err_nvalid_q;

endmodule

// File: tb/tb_add_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_add_issue_ctrl
//
// Self-checking bench for add_issue_ctrl. Contains a behavioural two-stage
// adder (with fault knobs forcing y to all-ones or holding valid low) and a
// transaction-level reference model: pairs accepted are queued, issues are
// matched in order, results are predicted as (a+b) mod 2^W and matched in
// order at the output handshake. Timing checks use the cycle numbers of the
// issue/return protocol directly.
// ---------------------------------------------------------------------------
module tb_add_issue_ctrl;

    localparam int W     = 8;
    localparam int DEPTH = 4;
    localparam int LAT   = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] y;
    logic         valid;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_sum;
    logic         busy;
    logic         err_mismatch;
    logic         err_nvalid;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    add_issue_ctrl #(.W(W), .DEPTH(DEPTH), .LAT(LAT)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .start        (start),
        .a            (a),
        .b            (b),
        .y            (y),
        .valid        (valid),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sum      (out_sum),
        .busy         (busy),
        .err_mismatch (err_mismatch),
        .err_nvalid   (err_nvalid)
    );

    // ---------------- behavioural two-stage adder (never reset) ----------
    logic [W-1:0] add_s1   = '0;
    logic [W-1:0] add_y    = '0;
    logic         add_v1   = 1'b0;
    logic         add_vld  = 1'b0;
    logic         force_ff = 1'b0;
    logic         tie0     = 1'b0;

    always @(posedge clk) begin
        add_v1 <= start;
        add_s1 <= a + b;
        if (add_v1) begin
            add_y   <= add_s1;
            add_vld <= 1'b1;
        end
    end

    assign y     = force_ff ? {W{1'b1}} : add_y;
    assign valid = tie0 ? 1'b0 : add_vld;

    // ---------------- reference model state ------------------------------
    logic            model_em  = 1'b0;
    logic            model_env = 1'b0;
    logic [2*W-1:0]  issue_q[$];
    logic [W-1:0]    res_q[$];
    int              n_acc = 0;
    int              n_ret = 0;
    logic            prev_hold = 1'b0;
    logic [W-1:0]    prev_sum  = '0;

    function automatic logic [W-1:0] mod_sum(input logic [W-1:0] x, input logic [W-1:0] z);
        int s;
        s = (int'(x) + int'(z)) % (1 << W);
        return W'(s);
    endfunction

    task automatic do_reset();
        @(posedge clk); #1;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(posedge clk); #1;
        rst       = 1'b0;
        model_em  = 1'b0;
        model_env = 1'b0;
        @(negedge clk);
    endtask

    // ---------------- reset values ---------------------------------------
    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_in_ready: got %b expected 0", in_ready);
        end
        n_checks++;
        if ({start, out_valid, busy, err_mismatch, err_nvalid} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got start=%b ov=%b busy=%b em=%b env=%b expected all 0",
                     start, out_valid, busy, err_mismatch, err_nvalid);
        end
        n_checks++;
        if ({a, b, out_sum} !== '0) begin
            n_fail++; $display("FAIL reset_data: got a=%0h b=%0h sum=%0h expected 0", a, b, out_sum);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL post_reset: got in_ready=%b busy=%b expected 1/0", in_ready, busy);
        end
    endtask

    // ---------------- one isolated operation with full timing check -------
    // Pair offered in cycle 0; start expected in cycle 2 only; result in
    // cycle LAT+3 (out_ready high so HOLD lasts one cycle).
    task automatic run_single(input logic [W-1:0] oa, input logic [W-1:0] ob, input string tag);
        logic [W-1:0] ys;
        logic [W-1:0] es;
        es = mod_sum(oa, ob);
        ys = force_ff ? {W{1'b1}} : es;
        out_ready = 1'b1;
        for (int c = 0; c <= LAT + 5; c++) begin
            @(posedge clk); #1;
            in_valid = (c == 0);
            in_a     = oa;
            in_b     = ob;
            @(negedge clk);
            if (c == 0) begin
                n_checks++;
                if (in_ready !== 1'b1) begin
                    n_fail++; $display("FAIL %s_accept: got in_ready=%b expected 1", tag, in_ready);
                end
            end
            n_checks++;
            if (start !== (c == 2)) begin
                n_fail++; $display("FAIL %s_start c%0d: got %b expected %b", tag, c, start, c == 2);
            end
            if (c == 2) begin
                n_checks++;
                if (a !== oa || b !== ob) begin
                    n_fail++; $display("FAIL %s_operands: got %0d,%0d expected %0d,%0d", tag, a, b, oa, ob);
                end
            end
            n_checks++;
            if (out_valid !== (c == LAT + 3)) begin
                n_fail++; $display("FAIL %s_out_valid c%0d: got %b expected %b", tag, c, out_valid, c == LAT + 3);
            end
            if (c == LAT + 3) begin
                model_em  = model_em | (ys != es);
                model_env = model_env | tie0;
                n_checks++;
                if (out_sum !== ys) begin
                    n_fail++; $display("FAIL %s_sum: got %0d expected %0d", tag, out_sum, ys);
                end
                n_checks++;
                if (err_mismatch !== model_em || err_nvalid !== model_env) begin
                    n_fail++;
                    $display("FAIL %s_errs: got em=%b env=%b expected em=%b env=%b",
                             tag, err_mismatch, err_nvalid, model_em, model_env);
                end
            end
        end
        in_valid = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL %s_idle: got busy=%b expected 0", tag, busy);
        end
    endtask

    task automatic test_single();
        do_reset();
        run_single(8'd3, 8'd4, "single");
    endtask

    task automatic test_wrap();
        run_single(8'd200, 8'd100, "wrap");
    endtask

    task automatic test_fault_mismatch();
        do_reset();
        force_ff = 1'b1;
        run_single(8'd1, 8'd1, "fault");
        force_ff = 1'b0;
        run_single(8'd2, 8'd3, "fault_sticky");
        run_single(8'd9, 8'd7, "fault_sticky2");
    endtask

    task automatic test_nvalid();
        do_reset();
        tie0 = 1'b1;
        run_single(8'd1, 8'd2, "nvalid");
        tie0 = 1'b0;
    endtask

    // ---------------- backpressure and in-order drain ---------------------
    task automatic test_backpressure();
        logic [W-1:0] exp_q[$];
        int cyc, got, last, h;
        do_reset();
        out_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_a     = W'($urandom);
            in_b     = W'($urandom);
            @(negedge clk);
            n_checks++;
            if (in_ready !== (c < DEPTH + 1)) begin
                n_fail++; $display("FAIL bp_in_ready c%0d: got %b expected %b", c, in_ready, c < DEPTH + 1);
            end
            if (in_ready) exp_q.push_back(mod_sum(in_a, in_b));
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_checks++;
        if (exp_q.size() != DEPTH + 1) begin
            n_fail++; $display("FAIL bp_accepted: got %0d expected %0d", exp_q.size(), DEPTH + 1);
        end
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL bp_hold: got ov=%b in_ready=%b expected 1/0", out_valid, in_ready);
        end
        out_ready = 1'b1;
        cyc = 0; got = 0; last = 0; h = -10;
        while (got < DEPTH + 1 && cyc < 200) begin
            if (cyc > 0) begin
                @(posedge clk); #1;
                @(negedge clk);
            end
            cyc++;
            if (cyc == h + 1) begin
                n_checks++;
                if (in_ready !== 1'b0) begin
                    n_fail++; $display("FAIL bp_ready_early: got %b expected 0", in_ready);
                end
            end
            if (cyc == h + 2) begin
                n_checks++;
                if (in_ready !== 1'b1) begin
                    n_fail++; $display("FAIL bp_ready_reassert: got %b expected 1", in_ready);
                end
            end
            if (out_valid) begin
                n_checks++;
                if (exp_q.size() == 0 || out_sum !== exp_q[0]) begin
                    n_fail++; $display("FAIL bp_order #%0d: got %0d expected %0d", got, out_sum,
                                       exp_q.size() ? exp_q[0] : 0);
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                if (got > 0) begin
                    n_checks++;
                    if (cyc - last != LAT + 3) begin
                        n_fail++; $display("FAIL bp_spacing: got %0d expected %0d", cyc - last, LAT + 3);
                    end
                end else begin
                    h = cyc;
                end
                last = cyc;
                got++;
            end
        end
        n_checks++;
        if (got != DEPTH + 1) begin
            n_fail++; $display("FAIL bp_drain_timeout: got %0d results expected %0d", got, DEPTH + 1);
        end
        out_ready = 1'b0;
    endtask

    // ---------------- reset during WAIT with pairs queued ----------------
    task automatic test_reset_mid();
        do_reset();
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_a     = W'(c + 10);
            in_b     = W'(c + 20);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || start !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_clear: got ov=%b busy=%b start=%b in_ready=%b expected 0/0/0/0",
                     out_valid, busy, start, in_ready);
        end
        @(posedge clk); #1;
        rst       = 1'b0;
        model_em  = 1'b0;
        model_env = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_release: got busy=%b in_ready=%b ov=%b expected 0/1/0",
                     busy, in_ready, out_valid);
        end
        run_single(8'd5, 8'd6, "after_rst");
    endtask

    // ---------------- randomized traffic against the queue model ---------
    task automatic sb_sample(input string tag);
        int outstanding;
        if (prev_hold) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_sum !== prev_sum) begin
                n_fail++; $display("FAIL %s_hold_stable: got ov=%b sum=%0d expected 1/%0d",
                                   tag, out_valid, out_sum, prev_sum);
            end
        end
        outstanding = n_acc - n_ret;
        if (outstanding == DEPTH + 1) begin
            n_checks++;
            if (in_ready !== 1'b0) begin
                n_fail++; $display("FAIL %s_full_ready: got %b expected 0", tag, in_ready);
            end
        end else if (outstanding < DEPTH) begin
            n_checks++;
            if (in_ready !== 1'b1) begin
                n_fail++; $display("FAIL %s_space_ready: got %b expected 1 (outstanding %0d)",
                                   tag, in_ready, outstanding);
            end
        end
        if (start) begin
            n_checks++;
            if (issue_q.size() == 0 || {a, b} !== issue_q[0]) begin
                n_fail++; $display("FAIL %s_issue: got %0h expected %0h", tag, {a, b},
                                   issue_q.size() ? issue_q[0] : '0);
            end
            if (issue_q.size() != 0) begin
                res_q.push_back(mod_sum(issue_q[0][2*W-1:W], issue_q[0][W-1:0]));
                void'(issue_q.pop_front());
            end
        end
        if (out_valid && out_ready) begin
            n_checks++;
            if (res_q.size() == 0 || out_sum !== res_q[0]) begin
                n_fail++; $display("FAIL %s_result: got %0d expected %0d", tag, out_sum,
                                   res_q.size() ? res_q[0] : '0);
            end
            if (res_q.size() != 0) void'(res_q.pop_front());
            n_ret++;
        end
        if (in_valid && in_ready) begin
            issue_q.push_back({in_a, in_b});
            n_acc++;
        end
        prev_hold = out_valid && !out_ready;
        prev_sum  = out_sum;
    endtask

    task automatic test_random();
        int guard;
        do_reset();
        issue_q.delete();
        res_q.delete();
        n_acc = 0; n_ret = 0; prev_hold = 1'b0;
        for (int i = 0; i < 800; i++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 2) != 0);
            in_a      = W'($urandom);
            in_b      = W'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            sb_sample("rand");
        end
        guard = 0;
        while ((n_ret != n_acc || busy) && guard < 300) begin
            @(posedge clk); #1;
            in_valid  = 1'b0;
            out_ready = 1'b1;
            @(negedge clk);
            sb_sample("drain");
            guard++;
        end
        n_checks++;
        if (n_ret != n_acc || busy !== 1'b0) begin
            n_fail++; $display("FAIL rand_drain_timeout: got %0d returned expected %0d", n_ret, n_acc);
        end
        n_checks++;
        if (err_mismatch !== 1'b0 || err_nvalid !== 1'b0) begin
            n_fail++; $display("FAIL rand_errs: got em=%b env=%b expected 0/0", err_mismatch, err_nvalid);
        end
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_fault_mismatch();
        test_nvalid();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
